// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment digit-scan logic.
package seg_pkg;

  localparam int CNT_MAX_DEF = 50_000_000;
  localparam int DIGITS_DEF  = 8;

  // Sized for the widest supported display; users slice down to DIGITS.
  localparam logic [7:0] SEL_OFF  = 8'hFF;
  localparam logic [7:0] SEL_DIG0 = 8'hFE;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Slot prescaler: counts clocks within a digit slot and flags the last one.
module seg_tick_gen #(
  parameter int CNT_MAX = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic wrap
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [CNT_W-1:0] cnt0_q, cnt0_d;

  // A held cycle never wraps, so the slot is stretched rather than skipped.
  assign wrap = !clear && !hold && (cnt0_q == CNT_LAST);

  always_comb begin
    cnt0_d = cnt0_q;
    if (clear || wrap) begin
      cnt0_d = '0;
    end else if (!hold) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit-scan driver: active-low one-hot digit select, digit index and
// per-slot / per-frame strobes for the segment decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int IDX_W   = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              scan_en,
  input  logic              hold,
  output logic [DIGITS-1:0] led_cnt,
  output logic [IDX_W-1:0]  dig_idx,
  output logic              end_cnt0,
  output logic              frame_done
);

  localparam logic [DIGITS-1:0] SEL_OFF_W  = SEL_OFF[DIGITS-1:0];
  localparam logic [DIGITS-1:0] SEL_DIG0_W = SEL_DIG0[DIGITS-1:0];
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t            state_q, state_d;
  logic [DIGITS-1:0] led_cnt_q, led_cnt_d;
  logic [IDX_W-1:0]  dig_idx_q, dig_idx_d;
  logic              end_cnt0_q, end_cnt0_d;
  logic              frame_done_q, frame_done_d;
  logic [IDX_W-1:0]  idx_next;
  logic              tick_clear;
  logic              tick_wrap;

  // The prescaler sits at zero whenever we are idle or about to drop out of RUN,
  // so every (re)entry into RUN starts a fresh full slot.
  assign tick_clear = (state_q == IDLE) || !scan_en;

  seg_tick_gen #(
    .CNT_MAX (CNT_MAX)
  ) u_tick (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clear (tick_clear),
    .hold  (hold),
    .wrap  (tick_wrap)
  );

  assign idx_next = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    led_cnt_d    = led_cnt_q;
    dig_idx_d    = dig_idx_q;
    end_cnt0_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        led_cnt_d = SEL_OFF_W;
        dig_idx_d = '0;
        if (scan_en) begin
          state_d    = RUN;
          led_cnt_d  = SEL_DIG0_W;
          end_cnt0_d = 1'b1;
        end
      end
      RUN: begin
        if (!scan_en) begin
          state_d   = IDLE;
          led_cnt_d = SEL_OFF_W;
          dig_idx_d = '0;
        end else if (tick_wrap) begin
          led_cnt_d    = {led_cnt_q[DIGITS-2:0], led_cnt_q[DIGITS-1]};
          dig_idx_d    = idx_next;
          end_cnt0_d   = 1'b1;
          frame_done_d = (idx_next == '0);
        end
      end
      default: begin
        state_d   = IDLE;
        led_cnt_d = SEL_OFF_W;
        dig_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      led_cnt_q    <= SEL_OFF_W;
      dig_idx_q    <= '0;
      end_cnt0_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_cnt_q    <= led_cnt_d;
      dig_idx_q    <= dig_idx_d;
      end_cnt0_q   <= end_cnt0_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign led_cnt    = led_cnt_q;
  assign dig_idx    = dig_idx_q;
  assign end_cnt0   = end_cnt0_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected strobe events (cycle, select,
// index, frame flag) are queued as stimulus is applied and popped on each strobe.
module tb_seg_scan_ctrl;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic [2:0] idx;
    logic       frame;
  } strobe_t;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       scan_en = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] led8;
  logic [2:0] idx8;
  logic       end8, frame8;

  logic       scan_en4 = 1'b0;
  logic       hold4 = 1'b0;
  logic [3:0] led4;
  logic [1:0] idx4;
  logic       end4, frame4;
  logic       run4 = 1'b0;

  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;
  int base;
  strobe_t q8[$];
  strobe_t q4[$];

  seg_scan_ctrl #(.CNT_MAX(4), .DIGITS(8), .IDX_W(3)) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .scan_en    (scan_en),
    .hold       (hold),
    .led_cnt    (led8),
    .dig_idx    (idx8),
    .end_cnt0   (end8),
    .frame_done (frame8)
  );

  seg_scan_ctrl #(.CNT_MAX(2), .DIGITS(4), .IDX_W(2)) dut4 (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .scan_en    (scan_en4),
    .hold       (hold4),
    .led_cnt    (led4),
    .dig_idx    (idx4),
    .end_cnt0   (end4),
    .frame_done (frame4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic strobe_t mkStrobe(input int c, input int k, input int digits);
    strobe_t    s;
    logic [7:0] one;
    one     = 8'h01 << (k % digits);
    s.cyc   = c;
    s.led   = ~one;
    s.idx   = 3'(k % digits);
    s.frame = (k > 0) && ((k % digits) == 0);
    return s;
  endfunction

  task automatic applyStimulus(input logic en, input logic hl, input int n);
    scan_en = en;
    hold    = hl;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    strobe_t e;
    if (end8) begin
      checkOutput("q8_has_entry", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        checkOutput("strobe8_cycle", cyc, e.cyc);
        checkOutput("strobe8_led", {24'd0, led8}, {24'd0, e.led});
        checkOutput("strobe8_idx", {29'd0, idx8}, {29'd0, e.idx});
        checkOutput("strobe8_frame", {31'd0, frame8}, {31'd0, e.frame});
      end
    end
    checkOutput("frame8_alone", {31'd0, frame8 & ~end8}, 32'd0);
  end

  always @(negedge clk) begin
    strobe_t e;
    if (end4) begin
      checkOutput("q4_has_entry", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        checkOutput("strobe4_cycle", cyc, e.cyc);
        checkOutput("strobe4_led", {28'd0, led4}, {28'd0, e.led[3:0]});
        checkOutput("strobe4_idx", {30'd0, idx4}, {29'd0, e.idx});
        checkOutput("strobe4_frame", {31'd0, frame4}, {31'd0, e.frame});
      end
    end
    checkOutput("frame4_alone", {31'd0, frame4 & ~end4}, 32'd0);
    if (run4) begin
      checkOutput("onehot4", $countones(~led4), 32'd1);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_led8", {24'd0, led8}, 32'hFF);
    checkOutput("rst_idx8", {29'd0, idx8}, 32'd0);
    checkOutput("rst_end8", {31'd0, end8}, 32'd0);
    checkOutput("rst_frame8", {31'd0, frame8}, 32'd0);
    checkOutput("rst_led4", {28'd0, led4}, 32'hF);
    sys_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("idle_led8", {24'd0, led8}, 32'hFF);
    checkOutput("idle_idx8", {29'd0, idx8}, 32'd0);

    // Ten slots: a full frame plus the wrap back to digit 0 and one more.
    base = cyc;
    for (int k = 0; k < 10; k++) q8.push_back(mkStrobe(base + 1 + 4 * k, k, 8));
    applyStimulus(1'b1, 1'b0, 40);
    checkOutput("q8_drain_run", q8.size(), 32'd0);

    // Now at the last cycle of the digit-1 slot; hold for five edges.
    base = cyc;
    q8.push_back(mkStrobe(base + 6, 10, 8));
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("hold_led8", {24'd0, led8}, 32'hFD);
    checkOutput("hold_idx8", {29'd0, idx8}, 32'd1);
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("q8_drain_hold", q8.size(), 32'd0);

    // Last cycle of the digit-2 slot: drop scan_en on the wrap edge.
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("abort_led8", {24'd0, led8}, 32'hFF);
    checkOutput("abort_idx8", {29'd0, idx8}, 32'd0);
    checkOutput("abort_end8", {31'd0, end8}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2);

    base = cyc;
    for (int k = 0; k < 4; k++) q8.push_back(mkStrobe(base + 1 + 4 * k, k, 8));
    applyStimulus(1'b1, 1'b0, 15);
    checkOutput("pre_rst_led8", {24'd0, led8}, 32'hF7);
    checkOutput("q8_drain_reen", q8.size(), 32'd0);

    // Asynchronous reset pulse in the middle of a slot, released before the next edge.
    base = cyc;
    q8.push_back(mkStrobe(base + 1, 0, 8));
    q8.push_back(mkStrobe(base + 5, 1, 8));
    #2 sys_rst = 1'b1;
    #1;
    checkOutput("async_led8", {24'd0, led8}, 32'hFF);
    checkOutput("async_idx8", {29'd0, idx8}, 32'd0);
    checkOutput("async_end8", {31'd0, end8}, 32'd0);
    checkOutput("async_frame8", {31'd0, frame8}, 32'd0);
    #1 sys_rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_led8", {24'd0, led8}, 32'hFE);
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("q8_drain_rst", q8.size(), 32'd0);
    applyStimulus(1'b0, 1'b0, 1);

    // Four-digit instance with two-cycle slots.
    base = cyc;
    for (int k = 0; k < 9; k++) q4.push_back(mkStrobe(base + 1 + 2 * k, k, 4));
    scan_en4 = 1'b1;
    @(negedge clk);
    run4 = 1'b1;
    repeat (17) @(negedge clk);
    checkOutput("q4_drain_run", q4.size(), 32'd0);
    scan_en4 = 1'b0;
    run4 = 1'b0;
    @(negedge clk);
    checkOutput("idle_led4", {28'd0, led4}, 32'hF);
    checkOutput("idle_led8_end", {24'd0, led8}, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
